// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: a small CSR set, interrupt
// prioritisation, trap entry/return redirects and a free-running 64-bit
// cycle counter.
module csr_trap_unit #(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic [XLEN-1:0] pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic            mret,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_pc,
  output logic            mret_taken,
  output logic [XLEN-1:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  typedef enum logic {RUN, HANDLER} state_t;

  state_t          state_q, state_d;
  logic            mstatus_mie, mstatus_mpie;
  // Interrupt enable/pending bits packed as {external(11), timer(7), software(3)}.
  logic [2:0]      mie_r, mip_r, pending;
  logic [XLEN-1:0] mtvec_r, mepc_r, mcause_r;
  logic [63:0]     mcycle_r, mcycle_d;

  logic [XLEN-1:0] rd, wv;
  logic            hit, csr_we, int_flag;
  logic [3:0]      code;

  // CSR read mux: old value of the addressed register, 0 when unimplemented.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    rd  = '0;
    hit = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        rd[3] = mstatus_mie;
        rd[7] = mstatus_mpie;
      end
      ADDR_MIE: begin
        rd[11] = mie_r[2];
        rd[7]  = mie_r[1];
        rd[3]  = mie_r[0];
      end
      ADDR_MTVEC:  rd = mtvec_r;
      ADDR_MEPC:   rd = mepc_r;
      ADDR_MCAUSE: rd = mcause_r;
      ADDR_MIP: begin
        rd[11] = mip_r[2];
        rd[7]  = mip_r[1];
        rd[3]  = mip_r[0];
      end
      ADDR_MCYCLE: rd = mcycle_r[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) rd = XLEN'(mcycle_r[63:32]);
        else            hit = 1'b0;
      end
      default: hit = 1'b0;
    endcase
  end

  assign csr_rdata   = rd;
  assign csr_illegal = (csr_op != 2'b00) && !hit;

  // Read-modify-write value for the current CSR operation.
  always_comb begin
    case (csr_op)
      2'b01:   wv = csr_wdata;
      2'b10:   wv = rd | csr_wdata;
      2'b11:   wv = rd & ~csr_wdata;
      default: wv = rd;
    endcase
  end

  // Trap detection and cause selection: exception > external > software > timer.
  always_comb begin
    pending  = mip_r & mie_r & {3{mstatus_mie}};
    int_flag = 1'b0;
    code     = exc_cause;
    if (!exc_valid) begin
      if (pending[2]) begin
        int_flag = 1'b1;
        code     = 4'd11;
      end else if (pending[0]) begin
        int_flag = 1'b1;
        code     = 4'd3;
      end else if (pending[1]) begin
        int_flag = 1'b1;
        code     = 4'd7;
      end
    end
  end

  assign trap_taken = reset && (exc_valid || (pending != 3'b000));
  assign trap_pc    = {mtvec_r[XLEN-1:2], 2'b00} +
                      ((int_flag && mtvec_r[0]) ? XLEN'({code, 2'b00}) : '0);
  assign mret_taken = reset && mret && !trap_taken;
  assign epc        = mepc_r;
  // Traps and returns take precedence; a coincident CSR write is dropped.
  assign csr_we     = (csr_op != 2'b00) && hit && !trap_taken && !mret_taken;

  // Cycle counter next value: a write replaces only the addressed half.
  always_comb begin
    mcycle_d = mcycle_r + 64'd1;
    if (csr_we && csr_addr == ADDR_MCYCLE) begin
      if (XLEN == 32) mcycle_d = {mcycle_r[63:32], wv[31:0]};
      else            mcycle_d = 64'(wv);
    end else if (csr_we && csr_addr == ADDR_MCYCLEH && XLEN == 32) begin
      mcycle_d = {wv[31:0], mcycle_r[31:0]};
    end
  end

  // Handler-tracking state: enter on a trap, leave on a return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (trap_taken) state_d = HANDLER;
      HANDLER: if (mret_taken) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register and CSR updates, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q      <= RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r        <= '0;
      mip_r        <= '0;
      mtvec_r      <= '0;
      mepc_r       <= '0;
      mcause_r     <= '0;
      mcycle_r     <= '0;
    end else begin
      state_q  <= state_d;
      mip_r    <= {irq_ext, irq_timer, irq_sw};
      mcycle_r <= mcycle_d;
      if (trap_taken) begin
        mepc_r       <= pc & ~XLEN'(3);
        mcause_r     <= {int_flag, {(XLEN-5){1'b0}}, code};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_taken) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wv[3];
            mstatus_mpie <= wv[7];
          end
          ADDR_MIE:    mie_r    <= {wv[11], wv[7], wv[3]};
          ADDR_MTVEC:  mtvec_r  <= {wv[XLEN-1:2], 1'b0, wv[0] & VEC_EN};
          ADDR_MEPC:   mepc_r   <= {wv[XLEN-1:2], 2'b00};
          ADDR_MCAUSE: mcause_r <= wv;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit (XLEN=32, vectored mode enabled).
module tb_csr_trap_unit;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata, pc, trap_pc, epc;
  logic        csr_illegal, irq_ext, irq_timer, irq_sw;
  logic        exc_valid, mret, trap_taken, mret_taken;
  logic [3:0]  exc_cause;

  int n_checks = 0;
  int n_errors = 0;

  csr_trap_unit #(.XLEN(32), .VEC_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pc(pc), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .mret(mret),
    .trap_taken(trap_taken), .trap_pc(trap_pc),
    .mret_taken(mret_taken), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_do(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = w;
    tick();
    csr_op    = OP_NONE;
    csr_wdata = '0;
  endtask

  // Reads one CSR mid-cycle, then advances one clock.
  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_op   = OP_NONE;
    #1;
    check(name, csr_rdata, exp);
    tick();
  endtask

  initial begin
    vecs[0]  = '{A_MTVEC,   OP_RW,   32'h0000_2003, 32'h0000_0000, 1'b0};
    vecs[1]  = '{A_MTVEC,   OP_NONE, 32'h0,         32'h0000_2001, 1'b0};
    vecs[2]  = '{A_MEPC,    OP_RW,   32'h0000_0057, 32'h0000_0000, 1'b0};
    vecs[3]  = '{A_MEPC,    OP_NONE, 32'h0,         32'h0000_0054, 1'b0};
    vecs[4]  = '{A_MIE,     OP_RW,   32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[5]  = '{A_MIE,     OP_RC,   32'h0000_0080, 32'h0000_0888, 1'b0};
    vecs[6]  = '{A_MIE,     OP_NONE, 32'h0,         32'h0000_0808, 1'b0};
    vecs[7]  = '{A_MSTATUS, OP_RW,   32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{A_MSTATUS, OP_RC,   32'h0000_0088, 32'h0000_0088, 1'b0};
    vecs[9]  = '{A_MSTATUS, OP_NONE, 32'h0,         32'h0000_0000, 1'b0};
    vecs[10] = '{A_MCAUSE,  OP_RW,   32'h8000_0005, 32'h0000_0000, 1'b0};
    vecs[11] = '{A_MCAUSE,  OP_RS,   32'h0000_0002, 32'h8000_0005, 1'b0};
    vecs[12] = '{A_MCAUSE,  OP_NONE, 32'h0,         32'h8000_0007, 1'b0};
    vecs[13] = '{A_MIP,     OP_RW,   32'h0000_0FFF, 32'h0000_0000, 1'b0};
    vecs[14] = '{A_MIP,     OP_NONE, 32'h0,         32'h0000_0000, 1'b0};
    vecs[15] = '{12'h7C0,   OP_RW,   32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[16] = '{12'h7C0,   OP_NONE, 32'h0,         32'h0000_0000, 1'b0};
    vecs[17] = '{12'h301,   OP_RS,   32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[18] = '{A_MIE,     OP_RW,   32'h0000_0000, 32'h0000_0808, 1'b0};
    vecs[19] = '{A_MCAUSE,  OP_RW,   32'h0000_0000, 32'h8000_0007, 1'b0};
    vecs[20] = '{A_MEPC,    OP_RW,   32'h0000_0000, 32'h0000_0054, 1'b0};
    vecs[21] = '{A_MIE,     OP_NONE, 32'h0,         32'h0000_0000, 1'b0};

    // Reset with trap/mret requests active: both redirects must stay low.
    reset = 1'b0; csr_addr = A_MTVEC; csr_op = OP_NONE; csr_wdata = '0;
    pc = '0; irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
    exc_valid = 1'b1; exc_cause = 4'd2; mret = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_trap_taken", trap_taken, 1'b0);
    check("rst_mret_taken", mret_taken, 1'b0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_rdata", csr_rdata, 32'h0);
    exc_valid = 1'b0; mret = 1'b0; reset = 1'b1;
    csr_addr = A_MCYCLE;
    #1;
    check("mcycle_at_release", csr_rdata, 32'd0);
    repeat (5) tick();
    check("mcycle_counts", csr_rdata, 32'd5);

    // Table-driven CSR accesses: old value and illegal flag each cycle.
    for (int i = 0; i < 22; i++) begin
      csr_addr  = vecs[i].addr;
      csr_op    = vecs[i].op;
      csr_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_illegal", i), csr_illegal, vecs[i].exp_illegal);
      tick();
      csr_op = OP_NONE;
      csr_wdata = '0;
    end

    // mcycle low-half wrap carries into mcycleh; mcycleh write leaves low half.
    csr_do(A_MCYCLE, OP_RW, 32'hFFFF_FFFF);
    csr_addr = A_MCYCLE;  #1; check("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
    csr_addr = A_MCYCLEH; #1; check("mcycleh_before_wrap", csr_rdata, 32'h0);
    tick();
    csr_addr = A_MCYCLE;  #1; check("mcycle_wrapped", csr_rdata, 32'h0);
    csr_addr = A_MCYCLEH; #1; check("mcycleh_carry", csr_rdata, 32'h1);
    csr_do(A_MCYCLEH, OP_RW, 32'h7);
    csr_addr = A_MCYCLE;  #1; check("mcycle_held_on_h_write", csr_rdata, 32'h0);
    csr_addr = A_MCYCLEH; #1; check("mcycleh_written", csr_rdata, 32'h7);
    tick();

    // Vectored external interrupt, with a coincident mepc write dropped.
    csr_do(A_MSTATUS, OP_RS, 32'h8);
    csr_do(A_MIE, OP_RS, 32'h800);
    pc = 32'h100; irq_ext = 1'b1;
    #1; check("irq_latency", trap_taken, 1'b0);
    tick();
    csr_addr = A_MEPC; csr_op = OP_RW; csr_wdata = 32'h55;
    #1;
    check("ext_trap_taken", trap_taken, 1'b1);
    check("ext_trap_pc", trap_pc, 32'h202C);
    tick();
    csr_op = OP_NONE; csr_wdata = '0;
    #1;
    check("handler_masked", trap_taken, 1'b0);
    check("ext_epc", epc, 32'h100);
    rd_check("ext_mepc", A_MEPC, 32'h100);
    rd_check("ext_mcause", A_MCAUSE, 32'h8000_000B);
    rd_check("ext_mstatus", A_MSTATUS, 32'h80);

    // Return from handler, with a coincident mie write dropped.
    irq_ext = 1'b0; mret = 1'b1;
    csr_addr = A_MIE; csr_op = OP_RW; csr_wdata = 32'h0;
    #1;
    check("mret_taken", mret_taken, 1'b1);
    check("mret_epc", epc, 32'h100);
    check("mret_no_trap", trap_taken, 1'b0);
    tick();
    mret = 1'b0; csr_op = OP_NONE;
    rd_check("mret_mstatus", A_MSTATUS, 32'h88);
    rd_check("mret_mie_kept", A_MIE, 32'h800);
    check("run_no_trap", trap_taken, 1'b0);
    mret = 1'b1;
    #1; check("mret_in_run", mret_taken, 1'b1);
    tick();
    mret = 1'b0;
    rd_check("mret_run_mstatus", A_MSTATUS, 32'h88);

    // Exception with MIE=0, coincident with mret (trap wins).
    csr_do(A_MSTATUS, OP_RC, 32'h8);
    pc = 32'h200; exc_valid = 1'b1; exc_cause = 4'd2; mret = 1'b1;
    #1;
    check("exc_trap_taken", trap_taken, 1'b1);
    check("exc_trap_pc", trap_pc, 32'h2000);
    check("exc_blocks_mret", mret_taken, 1'b0);
    tick();
    exc_valid = 1'b0; mret = 1'b0;
    rd_check("exc_mcause", A_MCAUSE, 32'h2);
    rd_check("exc_mepc", A_MEPC, 32'h200);
    rd_check("exc_mstatus", A_MSTATUS, 32'h0);
    mret = 1'b1; tick(); mret = 1'b0;
    rd_check("exc_ret_mstatus", A_MSTATUS, 32'h80);

    // All three interrupts pending: external first, then software.
    csr_do(A_MIE, OP_RW, 32'h888);
    irq_ext = 1'b1; irq_sw = 1'b1; irq_timer = 1'b1;
    tick();
    pc = 32'h300;
    csr_addr = A_MSTATUS; csr_op = OP_RS; csr_wdata = 32'h8;
    #1; check("prio_masked", trap_taken, 1'b0);
    tick();
    csr_op = OP_NONE; csr_wdata = '0;
    #1;
    check("prio_ext_taken", trap_taken, 1'b1);
    check("prio_ext_pc", trap_pc, 32'h202C);
    tick();
    rd_check("prio_ext_cause", A_MCAUSE, 32'h8000_000B);
    irq_ext = 1'b0;
    tick(); tick();
    mret = 1'b1;
    #1; check("prio_mret", mret_taken, 1'b1);
    tick();
    mret = 1'b0;
    #1;
    check("prio_sw_taken", trap_taken, 1'b1);
    check("prio_sw_pc", trap_pc, 32'h200C);
    tick();
    rd_check("prio_sw_cause", A_MCAUSE, 32'h8000_0003);
    rd_check("prio_sw_mepc", A_MEPC, 32'h300);

    // Reset while in the handler with a trap and a CSR write in flight.
    reset = 1'b0; exc_valid = 1'b1; mret = 1'b1;
    csr_addr = A_MEPC; csr_op = OP_RW; csr_wdata = 32'h55;
    #1;
    check("midrst_trap_taken", trap_taken, 1'b0);
    check("midrst_mret_taken", mret_taken, 1'b0);
    tick();
    csr_op = OP_NONE; csr_wdata = '0;
    #1;
    check("midrst_trap_pc", trap_pc, 32'h0);
    check("midrst_epc", epc, 32'h0);
    rd_check("midrst_mstatus", A_MSTATUS, 32'h0);
    rd_check("midrst_mie", A_MIE, 32'h0);
    rd_check("midrst_mtvec", A_MTVEC, 32'h0);
    rd_check("midrst_mepc", A_MEPC, 32'h0);
    rd_check("midrst_mcause", A_MCAUSE, 32'h0);
    rd_check("midrst_mip", A_MIP, 32'h0);
    rd_check("midrst_mcycle", A_MCYCLE, 32'h0);
    rd_check("midrst_mcycleh", A_MCYCLEH, 32'h0);
    reset = 1'b1; exc_valid = 1'b0; mret = 1'b0;
    tick();
    check("post_rst_no_trap", trap_taken, 1'b0);
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width; legal values are 32 and 64.
REQ-002 SHALL have parameter VEC_EN, default 1, meaning vectored mtvec mode is supported (0: mode bits forced to direct).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port csr_addr, input, 12 bits: CSR address.
REQ-006 SHALL have port csr_op, input, 2 bits: 00 none, 01 write (RW), 10 set (RS), 11 clear (RC).
REQ-007 SHALL have port csr_wdata, input, XLEN bits: operand for csr_op.
REQ-008 SHALL have port csr_rdata, output, XLEN bits: old value of the addressed CSR.
REQ-009 SHALL have port csr_illegal, output, 1 bit: csr_op!=00 to an unimplemented address.
REQ-010 SHALL have port pc, input, XLEN bits: PC of the instruction in the trap-check stage.
REQ-011 SHALL have ports irq_ext, irq_timer and irq_sw, each input, 1 bit: level interrupt lines.
REQ-012 SHALL have port exc_valid, input, 1 bit, and port exc_cause, input, 4 bits: synchronous exception and its code.
REQ-013 SHALL have port mret, input, 1 bit: MRET executing.
REQ-014 SHALL have ports trap_taken (output, 1 bit) and trap_pc (output, XLEN bits): PC redirect to the handler.
REQ-015 SHALL have ports mret_taken (output, 1 bit) and epc (output, XLEN bits): return redirect, epc = mepc.

Function
REQ-016 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, and mcycleh 0xB80 (XLEN=32 only).
REQ-017 SHALL make csr_rdata combinational: the addressed CSR value whenever csr_addr is implemented, otherwise 0, independent of csr_op.
REQ-018 SHALL compute the new value as wdata (RW), old|wdata (RS) or old&~wdata (RC), and SHALL commit it at the next edge.
REQ-019 SHALL implement only bits 11, 7 and 3 of mie (MEIE, MTIE, MSIE) and of mip; other bits read 0.
REQ-020 SHALL keep mip bits 11/7/3 read-only, registered each cycle from irq_ext/irq_timer/irq_sw (one-cycle latency), and SHALL ignore writes to them.
REQ-021 SHALL force mepc[1:0] to 0, and mtvec[1] to 0; mtvec[0] SHALL be forced to 0 when VEC_EN=0.
REQ-022 SHALL increment the 64-bit mcycle every cycle out of reset; a CSR write to mcycle or mcycleh SHALL replace the written half that cycle instead of incrementing, and SHALL not alter the other half.
REQ-023 SHALL use a state machine with states RUN and HANDLER: RUN->HANDLER on trap_taken; HANDLER->RUN on mret_taken; other transitions hold.
REQ-024 SHALL define pending interrupt = mstatus.MIE & (mip & mie) over bits 11/7/3.
REQ-025 SHALL take a trap when exc_valid=1 or a pending interrupt exists, in either state; exceptions are never masked.
REQ-026 SHALL prioritise traps as exception > external(11) > software(3) > timer(7).
REQ-027 SHALL drive trap_taken and trap_pc combinationally in the trap cycle.
REQ-028 SHALL set trap_pc = {mtvec[XLEN-1:2],2'b00}, plus 4*code only for interrupts when mtvec[0]=1.
REQ-029 SHALL, at the edge ending a trap cycle, set mepc=pc, mcause={interrupt flag at bit XLEN-1, zeros, 4-bit code}, MPIE=MIE and MIE=0.
REQ-030 SHALL assert mret_taken combinationally when mret=1 and no trap is taken, and at that edge SHALL set MIE=MPIE and MPIE=1.
REQ-031 SHALL give simultaneous events this precedence: trap > mret > CSR write; a CSR write in a trap cycle or an mret cycle SHALL be discarded, while csr_illegal still reports.
REQ-032 SHALL make mret in state RUN still restore MIE/MPIE and assert mret_taken (no error).

Reset
REQ-033 SHALL, while reset=0 at a rising edge, clear all CSRs including mcycle and set state to RUN.
REQ-034 SHALL, while reset=0, hold trap_taken=0 and mret_taken=0; csr_rdata, trap_pc and epc SHALL read 0 after the first reset edge.
REQ-035 SHALL, when reset asserts mid-handler, discard any in-flight trap or CSR write and return to RUN with MIE=0.

Verification
REQ-036 SHALL cover: RS mstatus 0x8, RS mie 0x800, irq_ext=1, pc=0x100, mtvec=0x2001 -> one cycle after mip latch trap_taken=1, trap_pc=0x202C, then mepc=0x100, mcause=0x8000000B, mstatus=0x80.
REQ-037 SHALL cover: in HANDLER, mret=1 -> mret_taken=1, epc=0x100, mstatus=0x88, state RUN.
REQ-038 SHALL cover: exc_valid=1, exc_cause=2 with MIE=0 -> trap_taken=1, trap_pc=0x2000, mcause=0x2.
REQ-039 SHALL cover: irq_ext, irq_sw and irq_timer all pending -> cause 11 taken; after mret with irq_ext low -> cause 3 taken.
REQ-040 SHALL cover: RW mcycle 0xFFFFFFFF, XLEN=32 -> next cycle mcycle=0 and mcycleh incremented by 1; csr_op=01 at address 0x7C0 -> csr_illegal=1, csr_rdata=0.
REQ-041 SHALL cover: CSR RW mepc 0x55 coincident with a trap -> mepc=pc (write discarded); reset=0 mid-HANDLER -> all CSRs 0, state RUN.
